// File: rtl/mult_seq_pkg.sv
// Shared sizing and state encoding for the multi-cycle multiply sequencer.
`ifndef MULT_SEQ_PKG_SV
`define MULT_SEQ_PKG_SV

`define MULT_PROD_W(w) (2*(w))

package mult_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

endpackage

`endif

// File: rtl/mult_seq_if.sv
// Request/response and MTHI/MTLO bundle between the EX stage and the multiply sequencer.
interface mult_seq_if #(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, cancel, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, cancel, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_iter_core.sv
// Unsigned shift-add multiply datapath: one partial-product add and shift per step.
module mult_iter_core #(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic                            step,
    input  logic [WIDTH-1:0]                mcand,
    input  logic [WIDTH-1:0]                mplier,
    output logic                            last,
    output logic [`MULT_PROD_W(WIDTH)-1:0]  acc
);

    localparam int unsigned PW = `MULT_PROD_W(WIDTH);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand};
            mplier_q <= mplier;
            cnt      <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc <= acc + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt      <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_seq.sv
// MULT/MULTU sequencer owning HI/LO: magnitude multiply, sign fix-up, MTHI/MTLO and flush.
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
    input logic       clk,
    input logic       reset,
    mult_seq_if.slave bus
);

    localparam int unsigned PW = `MULT_PROD_W(WIDTH);

    mult_state_t      state;
    mult_state_t      next;
    logic             load;
    logic             step;
    logic             fix_we;
    logic             last;
    logic             neg;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    product;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    mult_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .mcand  (mag_a),
        .mplier (mag_b),
        .last   (last),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next   = state;
        load   = 1'b0;
        step   = 1'b0;
        fix_we = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    next = CALC;
                    load = 1'b1;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    next = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        next = FIX;
                    end
                end
            end
            FIX: begin
                next   = IDLE;
                fix_we = !bus.cancel;
            end
            default: next = IDLE;
        endcase
    end

    assign product = neg ? -acc : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (load) begin
                neg <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end
            busy_q <= (next != IDLE);
            done_q <= fix_we;
        end
    end

    // MTHI/MTLO only land while idle, so an in-flight product can never be clobbered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_we) begin
            hi_q <= product[PW-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
        end else if (state == IDLE) begin
            if (bus.hi_we) begin
                hi_q <= bus.wdata;
            end
            if (bus.lo_we) begin
                lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: vector table, scoreboard on done, and corner-case sequences.
module tb_mult_seq;

    logic clk;
    logic reset;

    mult_seq_if #(.WIDTH(32)) bus ();

    mult_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 11;
    vec_t        tbl [NV];
    logic [63:0] sb [$];
    int          checks;
    int          fails;
    int          dones;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (s) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return 64'(sa * sbv);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Every wait goes through here so a done pulse is always matched against the scoreboard.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk);
        if (bus.done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                check("hi_lo", {bus.hi, bus.lo}, exp);
            end
        end
    endtask

    // mode 1: stray start at cycle 5; mode 2: MTLO strobe at cycle 10
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int mode);
        int n;
        int lat;
        bus.is_signed = s;
        bus.a         = a;
        bus.b         = b;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        sb.push_back(exp);
        n   = 0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) n++;
            bus.start = (mode == 1 && lat == 5);
            if (mode == 1 && lat == 5) begin
                bus.a = 32'd9;
                bus.b = 32'd9;
            end
            bus.lo_we = (mode == 2 && lat == 10);
            if (mode == 2 && lat == 10) bus.wdata = 32'hAAAA_AAAA;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        check("done_seen", {63'd0, bus.done}, 64'd1);
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        check("busy_cycles", 64'(n), 64'd33);
        check("latency", 64'(lat), 64'd33);
        tick();
        check("done_pulse", {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        dones  = 0;
        tbl[0]  = '{"u_ffff",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1]  = '{"s_m1x2",     1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[2]  = '{"s_minxmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3]  = '{"s_7xm3",     1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[4]  = '{"u_zero",     1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[5]  = '{"s_maxxmax",  1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        tbl[6]  = '{"s_minx1",    1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7]  = '{"u_minx2",    1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        tbl[8]  = '{"s_m1xm1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[9]  = '{"u_ffffx2",   1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[10] = '{"s_0xmin",    1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cancel    = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        reset         = 1'b0;
        tick();
        tick();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 0);
        end

        for (int i = 0; i < 4; i++) begin
            logic        rs;
            logic [31:0] ra;
            logic [31:0] rb;
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            run_op(rs, ra, rb, model(rs, ra, rb), 0);
        end

        // MTHI in idle
        bus.wdata = 32'hDEAD_BEEF;
        bus.hi_we = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        check("mthi_idle", {32'd0, bus.hi}, {32'd0, 32'hDEAD_BEEF});

        // cancel mid-operation
        bus.wdata = 32'h1111_1111;
        bus.hi_we = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        bus.wdata = 32'h2222_2222;
        bus.lo_we = 1'b1;
        tick();
        bus.lo_we = 1'b0;
        check("preload", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222);
        bus.is_signed = 1'b0;
        bus.a         = 32'd5;
        bus.b         = 32'd6;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", {63'd0, bus.busy}, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("cancel_hilo", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222);
        run_op(1'b0, 32'd5, 32'd6, 64'd30, 0);

        // start while busy: only one done
        dones = 0;
        run_op(1'b0, 32'd3, 32'd4, 64'd12, 1);
        for (int i = 0; i < 40; i++) tick();
        check("one_done", 64'(dones), 64'd1);

        // MTLO while busy is dropped
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2);

        // asynchronous reset at cycle 20 of an operation
        bus.is_signed = 1'b0;
        bus.a         = 32'd3;
        bus.b         = 32'd3;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        run_op(1'b0, 32'd2, 32'd3, 64'd6, 0);

        for (int i = 0; i < 5; i++) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
